// File: rtl/softmax_in_ctrl_if.sv
// rtl/softmax_in_ctrl_if.sv - feature-memory read, input-buffer write and pass handshake bundle
interface softmax_in_ctrl_if #(
  parameter int TOUT   = 8,
  parameter int DAT_DW = 16,
  parameter int CH_W   = 12,
  parameter int PIX_W  = 12,
  parameter int ADDR_W = 20
);
  logic                   mem_rd_req;
  logic                   mem_rd_rdy;
  logic [ADDR_W-1:0]      mem_rd_addr;
  logic                   mem_rsp_vld;
  logic [TOUT*DAT_DW-1:0] mem_rsp_dat;
  logic                   buf_wr_vld;
  logic                   buf_wr_rdy;
  logic [TOUT*DAT_DW-1:0] buf_wr_dat;
  logic [CH_W-1:0]        ch_addr;
  logic [1:0]             pass_id;
  logic [PIX_W-1:0]       row_idx;
  logic                   last_word;
  logic                   pass_done;

  modport master (
    output mem_rd_req, mem_rd_addr, buf_wr_vld, buf_wr_dat,
           ch_addr, pass_id, row_idx, last_word,
    input  mem_rd_rdy, mem_rsp_vld, mem_rsp_dat, buf_wr_rdy, pass_done
  );

  modport slave (
    input  mem_rd_req, mem_rd_addr, buf_wr_vld, buf_wr_dat,
           ch_addr, pass_id, row_idx, last_word,
    output mem_rd_rdy, mem_rsp_vld, mem_rsp_dat, buf_wr_rdy, pass_done
  );
endinterface

// File: rtl/softmax_in_ctrl.sv
// rtl/softmax_in_ctrl.sv - row/pass/word sequencer feeding the softmax input buffer
// Each row runs MAX, SUM, NORM passes over ceil(CH/TOUT) words, waiting for the core between passes.
module softmax_in_ctrl #(
  parameter int TOUT   = 8,
  parameter int DAT_DW = 16,
  parameter int CH_W   = 12,
  parameter int PIX_W  = 12,
  parameter int ADDR_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [PIX_W-1:0]  cfg_pix,
  input  logic [ADDR_W-1:0] cfg_base,
  output logic              busy,
  output logic              done,
  softmax_in_ctrl_if.master bus
);
  localparam int LOG2_TOUT = $clog2(TOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT_RSP, S_PUSH, S_WAIT_PASS, S_DONE
  } state_t;

  state_t                 state_q;
  logic [CH_W:0]          words_q;
  logic [PIX_W-1:0]       pix_q;
  logic [ADDR_W-1:0]      row_base_q;
  logic [ADDR_W-1:0]      addr_q;
  logic [CH_W-1:0]        ch_q;
  logic [1:0]             pass_q;
  logic [PIX_W-1:0]       row_q;
  logic [TOUT*DAT_DW-1:0] dat_q;
  logic                   sticky_q;
  logic                   busy_q;
  logic                   done_q;

  logic [CH_W:0]          words_d;
  logic                   last_w;
  logic                   row_more;

  // Extra top bit keeps CH near 2^CH_W from wrapping before the divide.
  assign words_d  = ({1'b0, cfg_ch} + (CH_W+1)'(TOUT - 1)) >> LOG2_TOUT;
  assign last_w   = ({1'b0, ch_q} == words_q - (CH_W+1)'(1));
  assign row_more = ({1'b0, row_q} + (PIX_W+1)'(1)) < {1'b0, pix_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      words_q    <= '0;
      pix_q      <= '0;
      row_base_q <= '0;
      addr_q     <= '0;
      ch_q       <= '0;
      pass_q     <= '0;
      row_q      <= '0;
      dat_q      <= '0;
      sticky_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // A completion that beats the last word must not be lost.
      if (bus.pass_done && state_q != S_IDLE && state_q != S_DONE)
        sticky_q <= 1'b1;

      case (state_q)
        S_IDLE: begin
          if (start) begin
            pix_q <= cfg_pix;
            if (cfg_ch == '0 || cfg_pix == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              words_q    <= words_d;
              row_base_q <= cfg_base;
              addr_q     <= cfg_base;
              busy_q     <= 1'b1;
              state_q    <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (bus.mem_rd_rdy) state_q <= S_WAIT_RSP;
        end
        S_WAIT_RSP: begin
          if (bus.mem_rsp_vld) begin
            dat_q   <= bus.mem_rsp_dat;
            state_q <= S_PUSH;
          end
        end
        S_PUSH: begin
          if (bus.buf_wr_rdy) begin
            if (last_w) begin
              state_q <= S_WAIT_PASS;
            end else begin
              ch_q    <= ch_q + CH_W'(1);
              addr_q  <= addr_q + ADDR_W'(1);
              state_q <= S_REQ;
            end
          end
        end
        S_WAIT_PASS: begin
          if (sticky_q || bus.pass_done) begin
            sticky_q <= 1'b0;
            ch_q     <= '0;
            if (pass_q != 2'd2) begin
              pass_q  <= pass_q + 2'd1;
              addr_q  <= row_base_q;
              state_q <= S_REQ;
            end else if (row_more) begin
              pass_q     <= '0;
              row_q      <= row_q + PIX_W'(1);
              row_base_q <= row_base_q + ADDR_W'(words_q);
              addr_q     <= row_base_q + ADDR_W'(words_q);
              state_q    <= S_REQ;
            end else begin
              pass_q     <= '0;
              row_q      <= '0;
              words_q    <= '0;
              addr_q     <= '0;
              row_base_q <= '0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              state_q    <= S_DONE;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign bus.mem_rd_req  = (state_q == S_REQ);
  assign bus.mem_rd_addr = addr_q;
  assign bus.buf_wr_vld  = (state_q == S_PUSH) & bus.buf_wr_rdy;
  assign bus.buf_wr_dat  = dat_q;
  assign bus.ch_addr     = ch_q;
  assign bus.pass_id     = pass_q;
  assign bus.row_idx     = row_q;
  assign bus.last_word   = last_w;
endmodule

// File: tb/tb_softmax_in_ctrl.sv
// tb/tb_softmax_in_ctrl.sv - scoreboard bench for softmax_in_ctrl with memory and core models
module tb_softmax_in_ctrl;
  localparam int TOUT   = 8;
  localparam int DAT_DW = 16;
  localparam int CH_W   = 12;
  localparam int PIX_W  = 12;
  localparam int ADDR_W = 20;
  localparam int DW     = TOUT * DAT_DW;

  typedef struct {
    logic [DW-1:0]    dat;
    logic [CH_W-1:0]  ch;
    logic [1:0]       pass;
    logic [PIX_W-1:0] row;
    logic             last;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [CH_W-1:0]   cfg_ch;
  logic [PIX_W-1:0]  cfg_pix;
  logic [ADDR_W-1:0] cfg_base;
  logic              busy;
  logic              done;

  softmax_in_ctrl_if #(.TOUT(TOUT), .DAT_DW(DAT_DW), .CH_W(CH_W), .PIX_W(PIX_W), .ADDR_W(ADDR_W)) bus ();

  softmax_in_ctrl #(.TOUT(TOUT), .DAT_DW(DAT_DW), .CH_W(CH_W), .PIX_W(PIX_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_ch(cfg_ch), .cfg_pix(cfg_pix),
    .cfg_base(cfg_base), .busy(busy), .done(done), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0, n_rd = 0, n_stb = 0, n_done = 0;
  logic [ADDR_W-1:0] exp_rd[$];
  wr_t               exp_wr[$];

  int lat_fix = 0, pd_delay = 2;
  bit rnd_rdy = 0, hold_mode = 0, early_mode = 0;

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] mem_word(input logic [ADDR_W-1:0] a);
    logic [DW-1:0] w;
    for (int l = 0; l < TOUT; l++)
      w[l*DAT_DW +: DAT_DW] = a[15:0] ^ 16'(l * 'h1111) ^ {12'h5A0, a[19:16]};
    return w;
  endfunction

  // Reference: rows outermost, then three passes, then words; addresses wrap at 2^ADDR_W.
  task automatic expect_job(input int ch, input int pix, input int base);
    int  words;
    int  a;
    wr_t e;
    words = (ch + TOUT - 1) / TOUT;
    for (int r = 0; r < pix; r++)
      for (int p = 0; p < 3; p++)
        for (int w = 0; w < words; w++) begin
          a = (base + r * words + w) % (1 << ADDR_W);
          exp_rd.push_back(ADDR_W'(a));
          e.dat  = mem_word(ADDR_W'(a));
          e.ch   = CH_W'(w);
          e.pass = 2'(p);
          e.row  = PIX_W'(r);
          e.last = (w == words - 1);
          exp_wr.push_back(e);
        end
  endtask

  // Memory, buffer-ready and core models: observe at negedge, drive just after posedge.
  bit                drv_acc, drv_rspf, drv_stb, drv_stb_last, drv_reqlast, drv_outst, drv_early_sent;
  logic [ADDR_W-1:0] drv_acc_addr, drv_rsp_addr;
  int                drv_lat, drv_hold, drv_pd;

  initial begin
    bus.mem_rd_rdy  = 1'b1;
    bus.mem_rsp_vld = 1'b0;
    bus.mem_rsp_dat = '0;
    bus.buf_wr_rdy  = 1'b1;
    bus.pass_done   = 1'b0;
    drv_outst = 0; drv_lat = 0; drv_hold = 0; drv_pd = -1; drv_early_sent = 0;
    forever begin
      @(negedge clk);
      drv_acc      = bus.mem_rd_req & bus.mem_rd_rdy;
      drv_acc_addr = bus.mem_rd_addr;
      drv_rspf     = bus.mem_rsp_vld;
      drv_stb      = bus.buf_wr_vld;
      drv_stb_last = bus.last_word;
      drv_reqlast  = bus.mem_rd_req & bus.last_word;
      @(posedge clk);
      #1;
      bus.pass_done = 1'b0;
      if (drv_rspf) begin
        bus.mem_rsp_vld = 1'b0;
        drv_outst = 0;
      end
      if (drv_acc) begin
        drv_outst    = 1;
        drv_rsp_addr = drv_acc_addr;
        drv_lat      = (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 3));
      end
      if (drv_outst && !bus.mem_rsp_vld) begin
        if (drv_lat == 0) begin
          bus.mem_rsp_vld = 1'b1;
          bus.mem_rsp_dat = mem_word(drv_rsp_addr);
        end else drv_lat--;
      end
      bus.mem_rd_rdy = rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (drv_rspf && hold_mode) drv_hold = 7;
      if (drv_hold > 0) begin
        bus.buf_wr_rdy = 1'b0;
        drv_hold--;
      end else bus.buf_wr_rdy = rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (rst) begin
        drv_pd = -1;
        drv_early_sent = 0;
      end else if (early_mode) begin
        if (drv_stb && drv_stb_last) drv_early_sent = 0;
        else if (drv_reqlast && !drv_early_sent) begin
          bus.pass_done  = 1'b1;
          drv_early_sent = 1;
        end
      end else begin
        if (drv_stb && drv_stb_last) drv_pd = (pd_delay >= 0) ? pd_delay : int'($urandom_range(0, 3));
        else if (drv_pd > 0) drv_pd--;
        else if (drv_pd == 0) begin
          bus.pass_done = 1'b1;
          drv_pd = -1;
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a read or a buffer word.
  bit  mon_push = 0, mon_gap_on = 0;
  int  mon_gap = 0;
  wr_t mon_e;
  logic [ADDR_W-1:0] mon_a;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_push   = 0;
        mon_gap_on = 0;
      end else begin
        if (bus.mem_rd_req && bus.mem_rd_rdy) begin
          n_rd++;
          if (exp_rd.size() == 0) chk("read_not_expected", bus.mem_rd_req, 1'b0);
          else begin
            mon_a = exp_rd.pop_front();
            chk("rd_addr", bus.mem_rd_addr, mon_a);
          end
        end
        if (mon_gap_on) begin
          mon_gap++;
          if (bus.mem_rd_req || done) begin
            chk("wait_pass_cycles", mon_gap, 2);
            mon_gap_on = 0;
          end
        end
        if (mon_push) begin
          if (exp_wr.size() == 0) begin
            chk("word_not_expected", bus.buf_wr_vld, 1'b0);
            mon_push = 0;
          end else begin
            mon_e = exp_wr[0];
            chk("push_dat", bus.buf_wr_dat, mon_e.dat);
            chk("push_tag", {bus.ch_addr, bus.pass_id, bus.row_idx, bus.last_word},
                {mon_e.ch, mon_e.pass, mon_e.row, mon_e.last});
            chk("vld_follows_rdy", bus.buf_wr_vld, bus.buf_wr_rdy);
            if (bus.buf_wr_vld) begin
              n_stb++;
              void'(exp_wr.pop_front());
              mon_push = 0;
              if (early_mode && mon_e.last) begin
                mon_gap_on = 1;
                mon_gap    = 0;
              end
            end
          end
        end else chk("stray_strobe", bus.buf_wr_vld, 1'b0);
        if (bus.mem_rsp_vld && busy) mon_push = 1;
        if (done) n_done++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_req"}, bus.mem_rd_req, 1'b0);
    chk({tag, "_vld"}, bus.buf_wr_vld, 1'b0);
    chk({tag, "_last"}, bus.last_word, 1'b0);
    chk({tag, "_idx"}, {bus.ch_addr, bus.pass_id, bus.row_idx, bus.mem_rd_addr}, '0);
  endtask

  task automatic run_job(input int ch, input int pix, input int base, input bit poke_done);
    int rd0, st0, dn0, words;
    bit seen;
    rd0 = n_rd; st0 = n_stb; dn0 = n_done; seen = 0;
    words = (ch + TOUT - 1) / TOUT;
    expect_job(ch, pix, base);
    tick();
    start = 1'b1; cfg_ch = CH_W'(ch); cfg_pix = PIX_W'(pix); cfg_base = ADDR_W'(base);
    tick();
    start = 1'b0;
    chk("busy_after_start", busy, 1'b1);
    chk("first_req", {bus.mem_rd_req, bus.mem_rd_addr, bus.pass_id, bus.row_idx}, {1'b1, ADDR_W'(base), 2'd0, PIX_W'(0)});
    for (int c = 0; c < 8000 && !seen; c++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk("done_seen", seen, 1'b1);
    if (poke_done) begin
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (5) tick();
      chk("start_in_done_ignored", busy, 1'b0);
    end else tick();
    chk("busy_after_done", busy, 1'b0);
    chk("read_count", n_rd - rd0, 3 * pix * words);
    chk("strobe_count", n_stb - st0, 3 * pix * words);
    chk("done_pulses", n_done - dn0, 1);
    chk("scoreboard_drained", exp_rd.size() + exp_wr.size(), 0);
    exp_rd.delete();
    exp_wr.delete();
  endtask

  task automatic zero_job(input int ch, input int pix);
    int rd0, st0, dn0;
    rd0 = n_rd; st0 = n_stb; dn0 = n_done;
    tick();
    start = 1'b1; cfg_ch = CH_W'(ch); cfg_pix = PIX_W'(pix); cfg_base = 20'h00400;
    tick();
    start = 1'b0;
    chk("zero_done_next_cycle", done, 1'b1);
    chk("zero_busy", busy, 1'b0);
    tick();
    chk("zero_done_one_cycle", done, 1'b0);
    repeat (5) tick();
    chk("zero_traffic", {n_rd - rd0, n_stb - st0}, '0);
    chk("zero_done_pulses", n_done - dn0, 1);
  endtask

  initial begin
    int rd0, dn0;
    bit got_acc;
    rst = 1'b1; start = 1'b0; cfg_ch = '0; cfg_pix = '0; cfg_base = '0;
    repeat (3) tick();
    check_idle_outputs("reset");
    chk("reset_dat", bus.buf_wr_dat, '0);
    rst = 1'b0;

    // CH=20, PIX=2: three words per pass, start poked during DONE.
    run_job(20, 2, 'h100, 1);
    run_job(16, 1, 'h200, 0);

    hold_mode = 1;
    run_job(8, 1, 'h280, 0);
    hold_mode = 0;

    early_mode = 1;
    run_job(20, 1, 'h2A0, 0);
    early_mode = 0;

    zero_job(0, 3);
    zero_job(5, 0);

    // Reset in WAIT_RSP with a second start issued while busy; response arrives after reset.
    lat_fix = 3;
    expect_job(20, 2, 'h300);
    tick();
    start = 1'b1; cfg_ch = 12'd20; cfg_pix = 12'd2; cfg_base = 20'h00300;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1; cfg_ch = 12'd8; cfg_pix = 12'd1; cfg_base = 20'h00700;
    tick();
    start = 1'b0;
    got_acc = 0;
    for (int c = 0; c < 200 && !got_acc; c++) begin
      @(negedge clk);
      if (bus.mem_rd_req && bus.mem_rd_rdy) got_acc = 1;
    end
    chk("reset_test_reached_wait", got_acc, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_idle_outputs("midjob_reset");
    exp_rd.delete();
    exp_wr.delete();
    tick();
    rst = 1'b0;
    rd0 = n_rd; dn0 = n_done;
    repeat (10) tick();
    chk("no_second_job_busy", busy, 1'b0);
    chk("no_second_job_traffic", {n_rd - rd0, n_done - dn0}, '0);
    lat_fix = 0;
    run_job(9, 1, 'h300, 0);

    // Randomized jobs with random latency, ready and pass completion timing.
    rnd_rdy = 1; lat_fix = -1; pd_delay = -1;
    for (int i = 0; i < 6; i++) begin
      early_mode = (i % 3 == 2);
      run_job(int'($urandom_range(1, 40)), int'($urandom_range(1, 3)),
              (i == 0) ? 'hFFFFA : int'($urandom_range(0, 'hFFFFF)), 0);
    end
    early_mode = 0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
